// File: rtl/seg_scan_decoder_pkg.sv
// seg_pkg: shared definitions for the 7-segment scan decoder slice.
//   - SEG_0..SEG_F : active-high segment codes {a,b,c,d,e,f,g,dp}, dp = 0
//   - SEG_BLANK    : all segments off
//   - SEG_*_BIT    : bit position of each segment inside the byte
//   - SEG_AG_MASK  : keeps segments a..g, drops the decimal point
//   - S_IDLE/S_FILT/S_HELD : scan-tracker FSM encoding
//   - is_onehot / onehot_index : digit-select helpers
package seg_pkg;

  localparam logic [7:0] SEG_0 = 8'hFC;
  localparam logic [7:0] SEG_1 = 8'h60;
  localparam logic [7:0] SEG_2 = 8'hDA;
  localparam logic [7:0] SEG_3 = 8'hF2;
  localparam logic [7:0] SEG_4 = 8'h66;
  localparam logic [7:0] SEG_5 = 8'hB6;
  localparam logic [7:0] SEG_6 = 8'hBE;
  localparam logic [7:0] SEG_7 = 8'hE0;
  localparam logic [7:0] SEG_8 = 8'hFE;
  localparam logic [7:0] SEG_9 = 8'hF6;
  localparam logic [7:0] SEG_A = 8'hEE;
  localparam logic [7:0] SEG_B = 8'h3E;
  localparam logic [7:0] SEG_C = 8'h9C;
  localparam logic [7:0] SEG_D = 8'h7A;
  localparam logic [7:0] SEG_E = 8'h9E;
  localparam logic [7:0] SEG_F = 8'h8E;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam int SEG_A_BIT  = 7;
  localparam int SEG_B_BIT  = 6;
  localparam int SEG_C_BIT  = 5;
  localparam int SEG_D_BIT  = 4;
  localparam int SEG_E_BIT  = 3;
  localparam int SEG_F_BIT  = 2;
  localparam int SEG_G_BIT  = 1;
  localparam int SEG_DP_BIT = 0;

  localparam logic [7:0] SEG_AG_MASK = ~(8'(1) << SEG_DP_BIT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILT = 2'd1;
  localparam logic [1:0] S_HELD = 2'd2;

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

  // Index of the highest set bit; only meaningful for one-hot inputs.
  function automatic logic [2:0] onehot_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_pattern_decoder.sv
// seg_pattern_decoder: combinational segment-byte to hex-nibble lookup.
//   seg    in  8  segment byte {a,b,c,d,e,f,g,dp}, dp ignored
//   nibble out 4  decoded hex value (0 when invalid)
//   valid  out 1  byte matched one of the 16 hex glyphs
module seg_pattern_decoder
  import seg_pkg::*;
(
  input  logic [7:0] seg,
  output logic [3:0] nibble,
  output logic       valid
);

  logic [7:0] seg_ag;

  always_comb begin
    seg_ag = seg & SEG_AG_MASK;
    nibble = 4'h0;
    valid  = 1'b1;
    case (seg_ag)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: rebuilds the 32-bit word shown by an 8-digit multiplexed
// 7-segment driver by watching its select and segment outputs.
//   clk, rst     clock, asynchronous active-high reset
//   tub_sel[7:0] digit select, one-hot while a digit is lit
//   seg_74/seg_30 segment bytes for digits 7..4 / 3..0
//   word_out     last complete frame, digit i at [4i+3:4i]
//   frame_valid  one-cycle pulse when word_out is loaded
//   digit_mask   digits captured so far in the current frame
//   blank        select has been idle for BLANK_CYC cycles
//   pattern_err  sticky per frame: multi-hot select or unknown glyph seen
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYC = 4,
  parameter int BLANK_CYC  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  tub_sel,
  input  logic [7:0]  seg_74,
  input  logic [7:0]  seg_30,
  output logic [31:0] word_out,
  output logic        frame_valid,
  output logic [7:0]  digit_mask,
  output logic        blank,
  output logic        pattern_err
);

  localparam int STAB_W = $clog2(STABLE_CYC + 1);
  localparam int BLNK_W = $clog2(BLANK_CYC + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYC);
  localparam logic [BLNK_W-1:0] BLNK_MAX = BLNK_W'(BLANK_CYC);

  logic [1:0]        state, state_nx;
  logic [STAB_W-1:0] stab_cnt, stab_nx;
  logic [BLNK_W-1:0] blank_cnt;
  logic [7:0]        ref_sel_p1;
  logic [7:0]        ref_seg_p1;
  logic [3:0]        digit_q [8];

  logic [7:0]  seg_p0;
  logic        onehot_p0, multihot_p0, same_p0, idle_p0;
  logic [2:0]  idx_p0;
  logic [3:0]  dec_nib_p0;
  logic        dec_vld_p0;
  logic        load_ref, accept, frame_done, blank_hit;
  logic [7:0]  mask_acc;
  logic [31:0] word_nx;

  // ---- p0: raw sample classification (inputs share this clock domain) ----
  always_comb begin
    seg_p0      = (tub_sel[7:4] != 4'h0) ? seg_74 : seg_30;
    onehot_p0   = is_onehot(tub_sel);
    idle_p0     = (tub_sel == 8'h00);
    multihot_p0 = !idle_p0 && !onehot_p0;
    same_p0     = (tub_sel == ref_sel_p1) && (seg_p0 == ref_seg_p1);
    idx_p0      = onehot_index(tub_sel);
  end

  seg_pattern_decoder u_dec (
    .seg    (seg_p0),
    .nibble (dec_nib_p0),
    .valid  (dec_vld_p0)
  );

  // Dwell tracker: a digit is accepted once, on the sample that completes a
  // run of STABLE_CYC identical one-hot samples; S_HELD then ignores the rest
  // of the dwell so a long-lit digit is not counted twice.
  always_comb begin
    state_nx = state;
    stab_nx  = stab_cnt;
    load_ref = 1'b0;
    accept   = 1'b0;
    case (state)
      S_IDLE: begin
        if (onehot_p0) begin
          load_ref = 1'b1;
          stab_nx  = STAB_W'(1);
          if (STABLE_CYC == 1) begin
            accept   = 1'b1;
            state_nx = S_HELD;
          end else begin
            state_nx = S_FILT;
          end
        end
      end
      S_FILT, S_HELD: begin
        if (!onehot_p0) begin
          state_nx = S_IDLE;
          stab_nx  = '0;
        end else if (same_p0) begin
          if (state == S_FILT) begin
            stab_nx = stab_cnt + STAB_W'(1);
            if (stab_nx == STAB_MAX) begin
              accept   = 1'b1;
              state_nx = S_HELD;
            end
          end
        end else begin
          load_ref = 1'b1;
          stab_nx  = STAB_W'(1);
          if (STABLE_CYC == 1) begin
            accept   = 1'b1;
            state_nx = S_HELD;
          end else begin
            state_nx = S_FILT;
          end
        end
      end
      default: begin
        state_nx = S_IDLE;
        stab_nx  = '0;
      end
    endcase
  end

  // Frame assembly: the completing digit is merged in directly so word_out
  // carries it on the same edge it is accepted.
  always_comb begin
    mask_acc   = digit_mask | tub_sel;
    frame_done = accept && dec_vld_p0 && (mask_acc == 8'hFF);
    blank_hit  = idle_p0 && (blank_cnt == BLNK_MAX - BLNK_W'(1));
    word_nx    = '0;
    for (int i = 0; i < 8; i++) begin
      word_nx[4*i +: 4] = (idx_p0 == 3'(i)) ? dec_nib_p0 : digit_q[i];
    end
  end

  // ---- p1: control state and outputs ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      stab_cnt    <= '0;
      blank_cnt   <= '0;
      word_out    <= '0;
      frame_valid <= 1'b0;
      digit_mask  <= '0;
      blank       <= 1'b0;
      pattern_err <= 1'b0;
    end else begin
      state       <= state_nx;
      stab_cnt    <= stab_nx;
      frame_valid <= frame_done;

      if (!idle_p0)
        blank_cnt <= '0;
      else if (blank_cnt != BLNK_MAX)
        blank_cnt <= blank_cnt + BLNK_W'(1);

      if (blank_hit) begin
        blank      <= 1'b1;
        digit_mask <= '0;
      end

      if (accept) begin
        if (dec_vld_p0) begin
          blank <= 1'b0;
          if (frame_done) begin
            word_out    <= word_nx;
            digit_mask  <= '0;
            pattern_err <= 1'b0;
          end else begin
            digit_mask <= mask_acc;
          end
        end else begin
          pattern_err <= 1'b1;
        end
      end

      if (multihot_p0)
        pattern_err <= 1'b1;
    end
  end

  // ---- p1: datapath registers, no reset needed ----
  always_ff @(posedge clk) begin
    if (load_ref) begin
      ref_sel_p1 <= tub_sel;
      ref_seg_p1 <= seg_p0;
    end
    if (accept && dec_vld_p0)
      digit_q[idx_p0] <= dec_nib_p0;
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (STABLE_CYC=4, BLANK_CYC=1024).
module tb_seg_scan_decoder;
  import seg_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  tub_sel = 8'h00;
  logic [7:0]  seg_74 = 8'h00;
  logic [7:0]  seg_30 = 8'h00;
  logic [31:0] word_out;
  logic        frame_valid;
  logic [7:0]  digit_mask;
  logic        blank;
  logic        pattern_err;

  int n_vec = 0;
  int n_err = 0;
  int fv_pulses = 0;
  logic [7:0] code_tab [16];

  localparam logic [31:0] W1 = 32'h1234ABCD;
  localparam logic [31:0] W2 = 32'h89EF5D76;
  localparam logic [31:0] W3 = 32'h0F1E2D3C;
  localparam logic [31:0] W4 = 32'hFEDC0123;

  always #5 clk = ~clk;

  seg_scan_decoder #(.STABLE_CYC(4), .BLANK_CYC(1024)) dut (
    .clk         (clk),
    .rst         (rst),
    .tub_sel     (tub_sel),
    .seg_74      (seg_74),
    .seg_30      (seg_30),
    .word_out    (word_out),
    .frame_valid (frame_valid),
    .digit_mask  (digit_mask),
    .blank       (blank),
    .pattern_err (pattern_err)
  );

  task automatic step(input logic [7:0] s, input logic [7:0] b);
    tub_sel = s;
    if (s[7:4] != 4'h0) begin seg_74 = b; seg_30 = SEG_BLANK; end
    else begin seg_30 = b; seg_74 = SEG_BLANK; end
    @(posedge clk); #1;
    if (frame_valid) fv_pulses++;
  endtask

  task automatic show(input int d, input logic [7:0] b, input int n);
    for (int c = 0; c < n; c++) step(8'(1 << d), b);
  endtask

  task automatic scan(input logic [31:0] w, input int lo, input int hi);
    for (int d = lo; d <= hi; d++) show(d, code_tab[w[4*d +: 4]], 8);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (word_out !== 32'h0) begin n_err++; $display("FAIL rst_word: got %h want 00000000", word_out); end
    n_vec++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL rst_fv: got %b want 0", frame_valid); end
    n_vec++; if (digit_mask !== 8'h00) begin n_err++; $display("FAIL rst_mask: got %h want 00", digit_mask); end
    n_vec++; if (blank !== 1'b0) begin n_err++; $display("FAIL rst_blank: got %b want 0", blank); end
    n_vec++; if (pattern_err !== 1'b0) begin n_err++; $display("FAIL rst_perr: got %b want 0", pattern_err); end
    rst = 1'b0;
  endtask

  task automatic test_full_scan();
    int p;
    p = fv_pulses;
    scan(W1, 0, 6);
    n_vec++; if (digit_mask !== 8'h7F) begin n_err++; $display("FAIL scan_mask7: got %h want 7f", digit_mask); end
    show(7, code_tab[W1[31:28]], 3);
    n_vec++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL scan_fv_early: got %b want 0", frame_valid); end
    show(7, code_tab[W1[31:28]], 1);
    n_vec++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL scan_fv_4th: got %b want 1", frame_valid); end
    n_vec++; if (word_out !== W1) begin n_err++; $display("FAIL scan_word: got %h want %h", word_out, W1); end
    n_vec++; if (digit_mask !== 8'h00) begin n_err++; $display("FAIL scan_mask_clr: got %h want 00", digit_mask); end
    show(7, code_tab[W1[31:28]], 4);
    n_vec++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL scan_fv_after: got %b want 0", frame_valid); end
    n_vec++; if (fv_pulses - p !== 1) begin n_err++; $display("FAIL scan_pulses: got %0d want 1", fv_pulses - p); end
    n_vec++; if (pattern_err !== 1'b0) begin n_err++; $display("FAIL scan_perr: got %b want 0", pattern_err); end
  endtask

  task automatic test_glitch_filter();
    int p;
    p = fv_pulses;
    scan(W2, 0, 1);
    for (int k = 0; k < 3; k++) show(2, (k % 2 == 1) ? SEG_0 : SEG_8, 2);
    n_vec++; if (digit_mask !== 8'h03) begin n_err++; $display("FAIL glitch_noacc: got %h want 03", digit_mask); end
    show(2, SEG_D, 3);
    n_vec++; if (digit_mask !== 8'h03) begin n_err++; $display("FAIL glitch_run3: got %h want 03", digit_mask); end
    show(2, SEG_D, 1);
    n_vec++; if (digit_mask !== 8'h07) begin n_err++; $display("FAIL glitch_acc: got %h want 07", digit_mask); end
    n_vec++; if (pattern_err !== 1'b0) begin n_err++; $display("FAIL glitch_perr: got %b want 0", pattern_err); end
    show(2, SEG_D, 4);
    scan(W2, 3, 7);
    n_vec++; if (word_out !== W2) begin n_err++; $display("FAIL glitch_word: got %h want %h", word_out, W2); end
    n_vec++; if (fv_pulses - p !== 1) begin n_err++; $display("FAIL glitch_pulses: got %0d want 1", fv_pulses - p); end
  endtask

  task automatic test_multi_hot();
    int p;
    p = fv_pulses;
    scan(W3, 0, 3);
    step(8'h18, SEG_5);
    n_vec++; if (pattern_err !== 1'b1) begin n_err++; $display("FAIL mh_perr_set: got %b want 1", pattern_err); end
    n_vec++; if (digit_mask !== 8'h0F) begin n_err++; $display("FAIL mh_mask: got %h want 0f", digit_mask); end
    scan(W3, 4, 6);
    n_vec++; if (pattern_err !== 1'b1) begin n_err++; $display("FAIL mh_perr_sticky: got %b want 1", pattern_err); end
    scan(W3, 7, 7);
    n_vec++; if (word_out !== W3) begin n_err++; $display("FAIL mh_word: got %h want %h", word_out, W3); end
    n_vec++; if (pattern_err !== 1'b0) begin n_err++; $display("FAIL mh_perr_clr: got %b want 0", pattern_err); end
    n_vec++; if (fv_pulses - p !== 1) begin n_err++; $display("FAIL mh_pulses: got %0d want 1", fv_pulses - p); end
  endtask

  task automatic test_undecodable();
    int p;
    p = fv_pulses;
    scan(W4, 0, 4);
    show(5, 8'h02, 6);
    n_vec++; if (pattern_err !== 1'b1) begin n_err++; $display("FAIL undec_perr: got %b want 1", pattern_err); end
    n_vec++; if (digit_mask !== 8'h1F) begin n_err++; $display("FAIL undec_mask: got %h want 1f", digit_mask); end
    scan(W4, 6, 7);
    n_vec++; if (digit_mask !== 8'hDF) begin n_err++; $display("FAIL undec_mask_df: got %h want df", digit_mask); end
    n_vec++; if (fv_pulses - p !== 0) begin n_err++; $display("FAIL undec_nofv: got %0d want 0", fv_pulses - p); end
    n_vec++; if (word_out !== W3) begin n_err++; $display("FAIL undec_word_hold: got %h want %h", word_out, W3); end
    show(5, code_tab[W4[23:20]], 8);
    n_vec++; if (fv_pulses - p !== 1) begin n_err++; $display("FAIL undec_pulses: got %0d want 1", fv_pulses - p); end
    n_vec++; if (word_out !== W4) begin n_err++; $display("FAIL undec_word: got %h want %h", word_out, W4); end
    n_vec++; if (pattern_err !== 1'b0) begin n_err++; $display("FAIL undec_perr_clr: got %b want 0", pattern_err); end
  endtask

  task automatic test_blank();
    show(0, code_tab[3], 8);
    n_vec++; if (digit_mask !== 8'h01) begin n_err++; $display("FAIL blank_pre_mask: got %h want 01", digit_mask); end
    repeat (1023) step(8'h00, SEG_BLANK);
    n_vec++; if (blank !== 1'b0) begin n_err++; $display("FAIL blank_1023: got %b want 0", blank); end
    n_vec++; if (digit_mask !== 8'h01) begin n_err++; $display("FAIL blank_mask_1023: got %h want 01", digit_mask); end
    step(8'h00, SEG_BLANK);
    n_vec++; if (blank !== 1'b1) begin n_err++; $display("FAIL blank_1024: got %b want 1", blank); end
    n_vec++; if (digit_mask !== 8'h00) begin n_err++; $display("FAIL blank_mask: got %h want 00", digit_mask); end
    n_vec++; if (word_out !== W4) begin n_err++; $display("FAIL blank_word: got %h want %h", word_out, W4); end
    repeat (5) step(8'h00, SEG_BLANK);
    n_vec++; if (blank !== 1'b1) begin n_err++; $display("FAIL blank_hold: got %b want 1", blank); end
    show(3, code_tab[0], 3);
    n_vec++; if (blank !== 1'b1) begin n_err++; $display("FAIL blank_preacc: got %b want 1", blank); end
    show(3, code_tab[0], 1);
    n_vec++; if (blank !== 1'b0) begin n_err++; $display("FAIL blank_clr: got %b want 0", blank); end
    n_vec++; if (digit_mask !== 8'h08) begin n_err++; $display("FAIL blank_newmask: got %h want 08", digit_mask); end
  endtask

  task automatic test_async_reset();
    int p;
    scan(W1, 0, 5);
    n_vec++; if (digit_mask !== 8'h3F) begin n_err++; $display("FAIL ar_mask_pre: got %h want 3f", digit_mask); end
    #3;
    rst = 1'b1;
    #1;
    n_vec++; if (word_out !== 32'h0) begin n_err++; $display("FAIL ar_word: got %h want 00000000", word_out); end
    n_vec++; if (digit_mask !== 8'h00) begin n_err++; $display("FAIL ar_mask: got %h want 00", digit_mask); end
    n_vec++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL ar_fv: got %b want 0", frame_valid); end
    n_vec++; if (blank !== 1'b0) begin n_err++; $display("FAIL ar_blank: got %b want 0", blank); end
    n_vec++; if (pattern_err !== 1'b0) begin n_err++; $display("FAIL ar_perr: got %b want 0", pattern_err); end
    tub_sel = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    p = fv_pulses;
    scan(W1, 0, 5);
    n_vec++; if (digit_mask !== 8'h3F) begin n_err++; $display("FAIL ar_remask: got %h want 3f", digit_mask); end
    n_vec++; if (fv_pulses - p !== 0) begin n_err++; $display("FAIL ar_nofv: got %0d want 0", fv_pulses - p); end
    scan(W1, 6, 7);
    n_vec++; if (fv_pulses - p !== 1) begin n_err++; $display("FAIL ar_pulses: got %0d want 1", fv_pulses - p); end
    n_vec++; if (word_out !== W1) begin n_err++; $display("FAIL ar_word_new: got %h want %h", word_out, W1); end
  endtask

  initial begin
    code_tab = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                 SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
    test_reset();
    test_full_scan();
    test_glitch_filter();
    test_multi_hot();
    test_undecodable();
    test_blank();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Inverse of the 8-digit multiplexed 7-segment display driver.
- Samples the driver's `tub_sel`/`seg_74`/`seg_30` outputs and reconstructs the 32-bit hex word being shown, one nibble per digit.
- Sits beside the display driver as an on-chip self-check/readback path: `word_out` can be compared against the control module's `sign` bus.
- Flags illegal scan activity and a blanked (disabled) display.

Parameters:
- STABLE_CYC, 4, consecutive identical samples (`tub_sel` and active segment byte) required before a digit is accepted; min 1.
- BLANK_CYC, 1024, consecutive cycles of `tub_sel`==0 before the display is declared blank; min 2.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- tub_sel  input  8  digit select, active-high; bit i = digit i
- seg_74  input  8  segment byte for digits 7..4, active-high, {a,b,c,d,e,f,g,dp}
- seg_30  input  8  segment byte for digits 3..0, same encoding
- word_out  output  32  last complete frame; digit i at [4i+3:4i]
- frame_valid  output  1  one-cycle pulse when `word_out` updates
- digit_mask  output  8  digits captured in the current, incomplete frame
- blank  output  1  display is judged disabled
- pattern_err  output  1  sticky: multi-hot select or undecodable segment byte seen in the current frame

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - `word_out`=0, `frame_valid`=0, `digit_mask`=0, `blank`=0, `pattern_err`=0.
  - FSM=S_IDLE; all counters 0.
- Active byte selection: `seg_74` when `tub_sel[7:4]`≠0, else `seg_30`. The dp bit is ignored for decoding.
- Decode table (a..g → hex):
  - FC→0, 60→1, DA→2, F2→3, 66→4, B6→5, BE→6, E0→7
  - FE→8, F6→9, EE→A, 3E→b, 9C→C, 7A→d, 9E→E, 8E→F
  - Match uses byte with dp masked to 0. Any other pattern is undecodable.
- FSM:
  - S_IDLE: `tub_sel` not one-hot.
    - One-hot sample → S_FILT, stab_cnt=1, capture ref_sel/ref_seg.
    - Multi-hot (≥2 bits) sample → `pattern_err`=1, stay in S_IDLE.
  - S_FILT:
    - Sample equals ref → stab_cnt+1.
    - Sample differs but is still one-hot → reload ref, stab_cnt=1.
    - Sample not one-hot → S_IDLE.
    - On the edge where stab_cnt reaches STABLE_CYC → decode, then S_HELD.
      - Decodable: digit register updated, `digit_mask` bit set.
      - Undecodable: `pattern_err`=1, no store.
  - S_HELD:
    - Sample equals ref → stay.
    - Otherwise → same transitions as S_FILT on a change.
    - A digit is accepted at most once per dwell.
- STABLE_CYC=1: accept on the first one-hot sample (S_IDLE→S_HELD directly).
- Frame completion:
  - On the accept edge that makes `digit_mask`==FF, the same edge loads `word_out` with the assembled digits (including the digit just accepted).
  - Same edge: `frame_valid`=1 for exactly that one cycle; `digit_mask` cleared to 0; `pattern_err` cleared.
- Same digit re-accepted before the frame completes → nibble overwritten, mask unchanged.
- Blank detection:
  - blank_cnt counts consecutive `tub_sel`==0 samples and saturates at BLANK_CYC.
  - On reaching BLANK_CYC: `blank`=1, `digit_mask`=0.
  - `word_out` is held; `pattern_err` is held.
- `blank` clears on the next accepted digit.
- Any nonzero `tub_sel` zeroes blank_cnt.
- Inputs are sampled directly with no synchronizer; they come from the same clock domain.

Decomposition:
- Shared package seg_pkg:
  - The 16 segment-code constants (SEG_0..SEG_F).
  - SEG_BLANK=8'h00.
  - Segment bit-index constants.
  - FSM state encoding (S_IDLE, S_FILT, S_HELD).
- Sub-module seg_pattern_decoder: combinational, input 8-bit byte, outputs 4-bit nibble + valid. The matching display encoder and any bench model reuse the package constants.

Test Plan:
- Scan digits 0..7 with codes for word 32'h1234ABCD, 8 cycles/digit, STABLE_CYC=4 → exactly one `frame_valid` pulse, on the 4th cycle of digit 7; `word_out`=32'h1234ABCD; `digit_mask` returns to 00.
- During digit 2, hold `tub_sel`=04 but toggle the segment byte every 2 cycles, then hold 7A for 4 cycles → no accept until the stable run; digit 2 nibble = d; `pattern_err`=0.
- During a scan, drive `tub_sel`=0x18 for one cycle → `pattern_err`=1 until the next `frame_valid`; completed frame still correct.
- Digit 5 shows undecodable 0x02 for 6 cycles → `pattern_err`=1, `digit_mask[5]`=0, no `frame_valid` until digit 5 is later shown validly.
- `tub_sel`=0 for 1024 cycles after a valid frame → `blank`=1, `word_out` unchanged; next accepted digit clears `blank`.
- Assert `rst` while `digit_mask`=3F → all outputs 0 immediately (asynchronously, before the next clock edge); a fresh full scan is needed for `frame_valid`.
